// File: rtl/io_sequencer_pkg.sv
// io_sequencer_pkg
// Shared definitions for the I/O transaction sequencer: FSM state
// encodings, the I/O instruction opcode and the io-block control levels.
package io_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_ADDR_SETUP  = 3'd1,
        S_ADDR_STROBE = 3'd2,
        S_ADDR_HOLD   = 3'd3,
        S_DATA_SETUP  = 3'd4,
        S_DATA_STROBE = 3'd5,
        S_DATA_HOLD   = 3'd6,
        S_DONE        = 3'd7
    } state_t;

    localparam logic [3:0] IO_INSTR = 4'b0111;

    // IO_input_output levels
    localparam logic IO_IN  = 1'b0;
    localparam logic IO_OUT = 1'b1;

    // IO_data_address levels
    localparam logic IO_DATA = 1'b0;
    localparam logic IO_ADDR = 1'b1;

    function automatic logic is_strobe_state(input state_t s);
        return (s == S_ADDR_STROBE) || (s == S_DATA_STROBE);
    endfunction

endpackage

// File: rtl/io_sequencer_strobe_timer.sv
// io_strobe_timer
// Loadable, saturating up-counter shared by both strobe states.
// The count is the number of strobe cycles already completed, so the
// flags describe the cycle currently in progress:
//   min_met - this cycle is at least the STROBE_CYCLES-th strobe cycle
//   expired - this cycle is the TIMEOUT-th strobe cycle (or later)
// Ports:
//   clk, rst_n  - clock, synchronous active-low reset
//   load        - clear the count (held while outside a strobe state)
//   en          - advance the count by one, saturating at TIMEOUT
//   min_met     - minimum strobe width reached
//   expired     - timeout reached
module io_strobe_timer #(
    parameter int STROBE_CYCLES = 2,
    parameter int TIMEOUT       = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic min_met,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (en && (cnt != CW'(TIMEOUT))) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign min_met = (cnt >= CW'(STROBE_CYCLES - 1));
    assign expired = (cnt >= CW'(TIMEOUT - 1));

endmodule

// File: rtl/io_sequencer.sv
// io_sequencer
// Runs one complete two-phase transaction on the io block per start:
// an address phase (always output) followed by a data phase (input or
// output), each built from setup / strobe / hold windows. Reports read
// data and timeout status with a one-cycle done pulse.
//
// state         | meaning
// --------------+----------------------------------------------------
// S_IDLE        | waiting for start, busy=0
// S_ADDR_SETUP  | address and controls driven, strobes low (1 cycle)
// S_ADDR_STROBE | IO_clk_s high for STROBE_CYCLES, no ack needed
// S_ADDR_HOLD   | strobes low, address held (1 cycle)
// S_DATA_SETUP  | data controls / write data driven (1 cycle)
// S_DATA_STROBE | IO_clk_e (in) or IO_clk_s (out) until ack or timeout
// S_DATA_HOLD   | strobes low, data controls held (1 cycle)
// S_DONE        | done pulse, still busy (1 cycle)
//
// Ports:
//   clk, rst_n                     - clock, synchronous active-low reset
//   start, dir, port_addr, wr_data - transaction request from control unit
//   cpu_in, periph_ack             - data and acknowledge from io block
//   IO_data_address, IO_input_output, IO_clk_e, IO_clk_s, cpu_out
//                                  - io block controls and bus
//   rd_data, busy, done, err       - result and status to control unit
module io_sequencer
    import io_sequencer_pkg::*;
#(
    parameter int STROBE_CYCLES = 2,
    parameter int TIMEOUT       = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       dir,
    input  logic [7:0] port_addr,
    input  logic [7:0] wr_data,
    input  logic [7:0] cpu_in,
    input  logic       periph_ack,
    output logic       IO_data_address,
    output logic       IO_input_output,
    output logic       IO_clk_e,
    output logic       IO_clk_s,
    output logic [7:0] cpu_out,
    output logic [7:0] rd_data,
    output logic       busy,
    output logic       done,
    output logic       err
);

    state_t     state;
    logic       dir_q;
    logic [7:0] wdata_q;
    logic       min_met;
    logic       expired;
    logic       in_strobe;

    // Counter is held clear in every non-strobe state, so it starts
    // from zero on the entry edge of each strobe state.
    assign in_strobe = is_strobe_state(state);

    io_strobe_timer #(
        .STROBE_CYCLES (STROBE_CYCLES),
        .TIMEOUT       (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (!in_strobe),
        .en      (in_strobe),
        .min_met (min_met),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= S_IDLE;
            dir_q           <= IO_IN;
            wdata_q         <= 8'h00;
            IO_data_address <= 1'b0;
            IO_input_output <= 1'b0;
            IO_clk_e        <= 1'b0;
            IO_clk_s        <= 1'b0;
            cpu_out         <= 8'h00;
            rd_data         <= 8'h00;
            busy            <= 1'b0;
            done            <= 1'b0;
            err             <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        dir_q           <= dir;
                        wdata_q         <= wr_data;
                        err             <= 1'b0;
                        rd_data         <= 8'h00;
                        busy            <= 1'b1;
                        IO_data_address <= IO_ADDR;
                        IO_input_output <= IO_OUT;
                        cpu_out         <= port_addr;
                        state           <= S_ADDR_SETUP;
                    end
                end
                S_ADDR_SETUP: begin
                    IO_clk_s <= 1'b1;
                    state    <= S_ADDR_STROBE;
                end
                S_ADDR_STROBE: begin
                    if (min_met) begin
                        IO_clk_s <= 1'b0;
                        state    <= S_ADDR_HOLD;
                    end
                end
                S_ADDR_HOLD: begin
                    IO_data_address <= IO_DATA;
                    IO_input_output <= dir_q;
                    cpu_out         <= (dir_q == IO_OUT) ? wdata_q : 8'h00;
                    state           <= S_DATA_SETUP;
                end
                S_DATA_SETUP: begin
                    if (dir_q == IO_OUT) begin
                        IO_clk_s <= 1'b1;
                    end else begin
                        IO_clk_e <= 1'b1;
                    end
                    state <= S_DATA_STROBE;
                end
                S_DATA_STROBE: begin
                    // A late ack landing in the final allowed cycle still
                    // completes normally rather than timing out.
                    if (min_met && periph_ack) begin
                        IO_clk_e <= 1'b0;
                        IO_clk_s <= 1'b0;
                        rd_data  <= cpu_in;
                        state    <= S_DATA_HOLD;
                    end else if (expired) begin
                        IO_clk_e <= 1'b0;
                        IO_clk_s <= 1'b0;
                        rd_data  <= 8'h00;
                        err      <= 1'b1;
                        state    <= S_DATA_HOLD;
                    end
                end
                S_DATA_HOLD: begin
                    done  <= 1'b1;
                    state <= S_DONE;
                end
                S_DONE: begin
                    // Bus controls return to rest; strobes are already low.
                    busy            <= 1'b0;
                    IO_data_address <= 1'b0;
                    IO_input_output <= 1'b0;
                    cpu_out         <= 8'h00;
                    state           <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
